counter_axil_slave: RTL and testbench
=====================================

# counter_axil_slave

AXI4-Lite responder for the counter IP. It decodes four 32-bit registers (control, limit, live count, sticky status) and owns the free-running counter they configure. It sits behind the S00_AXI port of the IP wrapper and answers the AXI VIP master in the block-design bench. Write and read channels are handled by independent state machines, with at most one outstanding transaction per direction.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses bits [3:2].
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; prot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel; prot is ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- count_out  out  32  live counter value.
- wrap_pulse  out  1  one-cycle pulse on each wrap.

## Operation
- Register map (byte offset):
  - 0x0 CTRL: bit0 EN (RW); bit1 CLR (write-1 pulse, reads 0); other bits read 0.
  - 0x4 LIMIT: RW.
  - 0x8 COUNT: RW; a write loads the counter.
  - 0xC STATUS: bit0 WRAPPED, sticky, write-1-to-clear.
- WSTRB: honoured per byte for CTRL, LIMIT and COUNT. STATUS clears only when wstrb[0] is set and wdata[0]=1.
- Responses: bresp and rresp are always OKAY (2'b00). awaddr[1:0] and araddr[1:0] are ignored.
- Write FSM states:
  - W_IDLE: awready=wready=1.
  - W_ADDR: address held, awready=0, wready=1.
  - W_DATA: data held, awready=1, wready=0.
  - W_RESP: bvalid=1, both readies 0.
  - Transitions: IDLE goes to RESP if AW and W handshake on the same edge, to ADDR if only AW, to DATA if only W. ADDR and DATA go to RESP when the missing half arrives. RESP goes to IDLE on bvalid&&bready.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_RESP: rvalid=1, rdata held stable.
  - R_RESP goes to R_IDLE on rready.
- Counter, when EN=1: increments by 1 each cycle. When count==LIMIT, the next value is 0, wrap_pulse=1 for that cycle and WRAPPED sets. LIMIT=0 holds the count at 0 and wraps every cycle.
- Counter priority on one edge: CLR > COUNT write > wrap > increment. With EN=0 the count holds.
- WRAPPED: set wins over a simultaneous W1C.
- Reset: every register, count_out and wrap_pulse go to 0. All ready/valid outputs are 0 during reset, and rdata=0. The FSMs return to their IDLE states, abandoning any in-flight transaction with no response issued.

## Timing
- Readies are registered: 0 during reset, 1 from the first edge after reset deasserts.
- Write: the completing handshake at edge N updates the register at edge N. bvalid is high from cycle N+1 until bready.
- Read: the AR handshake at edge N samples the register at edge N. rvalid and rdata are valid from cycle N+1 until rready. Best-case throughput is one read per 2 cycles.
- Same-edge read and write to one register: the read returns the old value.
- count_out is registered and reflects COUNT with no extra delay. wrap_pulse is registered and coincides with count_out returning to 0.

## Structure
- Shared package counter_axil_pkg holds:
  - Register offsets: ADDR_CTRL, ADDR_LIMIT, ADDR_COUNT, ADDR_STATUS.
  - CTRL bit indices.
  - RESP_OKAY.
  - Enum typedefs wr_state_t and rd_state_t.
- One sub-module, counter_core: the counter, wrap logic and WRAPPED flag. It takes en, clr, load strobe/value, limit and w1c. The top keeps the AXI FSMs and register decode.

## Test plan
- Reset mid-write: drive AW only, then pulse s00_axi_areset before W arrives. Required: no bvalid, all readies 0 during reset, all registers 0 after.
- AW and W on the same cycle, then AW leading W by 3 cycles: write LIMIT=0x5 each way. Required: bvalid one cycle after the second handshake, bresp=0, LIMIT reads back 0x5.
- Strobed write: wstrb=4'b0010 with wdata=0xAABBCCDD to LIMIT=0. Required: LIMIT reads 0x0000CC00.
- Wrap: LIMIT=3, EN=1. Required: count_out sequence 0,1,2,3,0; wrap_pulse high exactly as count returns to 0; STATUS=1. Writing 1 to STATUS then reads 0.
- Counter collisions: write COUNT=0x10 while EN=1. Required: the next count is 0x10, not an increment. Write CTRL=0x3. Required: count goes to 0 and CTRL reads 0x1.
- Read backpressure: hold rready low for 4 cycles. Required: rvalid stays high with rdata stable, and arready=0 until the rready handshake.

Source files
------------

// File: rtl/counter_axil_pkg.sv
// Shared definitions for the counter AXI4-Lite slave: register map, CTRL bits, response codes, FSM states.
// Latency: none (package only).
// Backpressure: not applicable.
package counter_axil_pkg;

    // Register word indices, i.e. byte offset >> 2, compared against addr[3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LIMIT  = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // STATUS register bit positions
    localparam int STATUS_WRAPPED_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Byte-lane merge: lanes with a set strobe take the new value
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_core.sv
// Free-running counter with programmable wrap limit and a sticky WRAPPED flag.
// Latency: count/wrap_pulse/wrapped update on the edge that applies en/clr/load/w1c.
// Backpressure: none; inputs are single-cycle strobes.
module counter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic [31:0] limit,
    input  logic        w1c,
    output logic [31:0] count,
    output logic        wrap_pulse,
    output logic        wrapped
);

    logic [31:0] count_q, count_d;
    logic        wrap_pulse_q, wrap_pulse_d;
    logic        wrapped_q, wrapped_d;

    // Next count: clear beats load beats wrap beats increment; hold when disabled
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (count_q == limit) begin
                count_d      = '0;
                wrap_pulse_d = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        // A wrap on the same edge as a clear request keeps the flag set
        wrapped_d = wrap_pulse_d | (wrapped_q & ~w1c);
    end

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wrap_pulse_q <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrapped    = wrapped_q;

endmodule

// File: rtl/counter_axil_slave.sv
// AXI4-Lite slave exposing CTRL/LIMIT/COUNT/STATUS of the counter; independent write and read FSMs.
// Latency: write takes effect on the completing handshake edge, bvalid next cycle; rdata/rvalid one cycle after AR.
// Backpressure: one outstanding transaction per direction; readies drop while a response waits on bready/rready.
module counter_axil_slave
    import counter_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     count_out,
    output logic                            wrap_pulse
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic [31:0] limit_q, limit_d;

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_fire;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        core_clr, core_load, core_w1c;
    logic [31:0] core_load_val;
    logic [31:0] core_count;
    logic        core_wrapped;
    logic [31:0] rd_mux;

    // Protection bits and byte-offset bits within a word carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs = s00_axi_awvalid & awready_q;
    assign w_hs  = s00_axi_wvalid  & wready_q;
    assign ar_hs = s00_axi_arvalid & arready_q;

    // Write FSM: collect AW and W in either order, fire the register write when both are in
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_fire    = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = W_RESP;
                    wr_fire    = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = W_ADDR;
                end else if (w_hs) begin
                    wr_state_d = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_hs) begin
                    wr_state_d = W_RESP;
                    wr_fire    = 1'b1;
                end
            end
            W_DATA: begin
                if (aw_hs) begin
                    wr_state_d = W_RESP;
                    wr_fire    = 1'b1;
                end
            end
            W_RESP: begin
                if (bvalid_q && s00_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (aw_hs) begin
            awaddr_d = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            wdata_d = s00_axi_wdata;
            wstrb_d = s00_axi_wstrb;
        end
        // Channel outputs are registered images of the state being entered
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_DATA);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_ADDR);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    // Bypass the holding registers for whichever half arrives on the completing edge
    assign wr_addr = aw_hs ? s00_axi_awaddr[3:2] : awaddr_q;
    assign wr_data = w_hs  ? s00_axi_wdata       : wdata_q;
    assign wr_strb = w_hs  ? s00_axi_wstrb       : wstrb_q;

    // Register write decode, including the strobes into the counter core
    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        limit_d       = limit_q;
        core_clr      = 1'b0;
        core_load     = 1'b0;
        core_w1c      = 1'b0;
        core_load_val = apply_wstrb(core_count, wr_data, wr_strb);
        if (wr_fire) begin
            case (wr_addr)
                ADDR_CTRL: begin
                    if (wr_strb[0]) begin
                        ctrl_en_d = wr_data[CTRL_EN_BIT];
                        core_clr  = wr_data[CTRL_CLR_BIT];
                    end
                end
                ADDR_LIMIT:  limit_d   = apply_wstrb(limit_q, wr_data, wr_strb);
                ADDR_COUNT:  core_load = |wr_strb;
                ADDR_STATUS: core_w1c  = wr_strb[0] & wr_data[STATUS_WRAPPED_BIT];
                default: ;
            endcase
        end
    end

    // Read data mux over current register values
    always_comb begin
        rd_mux = '0;
        case (s00_axi_araddr[3:2])
            ADDR_CTRL:   rd_mux[CTRL_EN_BIT]        = ctrl_en_q;
            ADDR_LIMIT:  rd_mux                     = limit_q;
            ADDR_COUNT:  rd_mux                     = core_count;
            ADDR_STATUS: rd_mux[STATUS_WRAPPED_BIT] = core_wrapped;
            default:     rd_mux                     = '0;
        endcase
    end

    // Read FSM: capture on AR, hold rdata until rready
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_RESP;
                    rdata_d    = rd_mux;
                end
            end
            R_RESP: begin
                if (s00_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_RESP);
    end

    // AXI state, channel handshakes and configuration registers
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ctrl_en_q  <= 1'b0;
            limit_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ctrl_en_q  <= ctrl_en_d;
            limit_q    <= limit_d;
        end
    end

    counter_core u_core (
        .clk        (s00_axi_aclk),
        .rst        (s00_axi_areset),
        .en         (ctrl_en_q),
        .clr        (core_clr),
        .load       (core_load),
        .load_val   (core_load_val),
        .limit      (limit_q),
        .w1c        (core_w1c),
        .count      (core_count),
        .wrap_pulse (wrap_pulse),
        .wrapped    (core_wrapped)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign count_out       = core_count;

endmodule

// File: tb/tb_counter_axil_slave.sv
// Directed bench for counter_axil_slave: reset, write ordering, strobes, wrap, collisions, read backpressure.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bready held high by default; rready driven low for the backpressure step.
module tb_counter_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] count_out;
    logic        wrap_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .count_out       (count_out),
        .wrap_pulse      (wrap_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Simultaneous AW+W; returns just after the completing edge with bvalid checked
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_done, w_done, aw_acc, w_acc;
        int n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            n++;
            if (aw_acc) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_acc)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_bvalid", {31'b0, bvalid}, 32'd1);
        chk("wr_bresp", {30'b0, bresp}, 32'd0);
    endtask

    // Single read; rready stays high so the R handshake completes on the next edge
    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        int n;
        n       = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        chk("rd_arready", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
        chk("rd_rresp", {30'b0, rresp}, 32'd0);
        d = rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        int n;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b1;

        // Reset state
        #2;
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_count", count_out, 32'd0);
        chk("rst_wrap", {31'b0, wrap_pulse}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("post_rst_awready_before_edge", {31'b0, awready}, 32'd0);
        tick();
        chk("post_rst_awready", {31'b0, awready}, 32'd1);
        chk("post_rst_wready", {31'b0, wready}, 32'd1);
        chk("post_rst_arready", {31'b0, arready}, 32'd1);

        // Reset in the middle of a write (AW accepted, W never sent)
        awaddr = 4'h4;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("midwr_awready", {31'b0, awready}, 32'd0);
        chk("midwr_wready", {31'b0, wready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midwr_rst_awready", {31'b0, awready}, 32'd0);
        chk("midwr_rst_wready", {31'b0, wready}, 32'd0);
        chk("midwr_rst_arready", {31'b0, arready}, 32'd0);
        chk("midwr_rst_bvalid", {31'b0, bvalid}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midwr_no_bvalid", {31'b0, bvalid}, 32'd0);
        end
        rd(4'h0, v); chk("midwr_ctrl", v, 32'd0);
        rd(4'h4, v); chk("midwr_limit", v, 32'd0);
        rd(4'h8, v); chk("midwr_count", v, 32'd0);
        rd(4'hC, v); chk("midwr_status", v, 32'd0);

        // LIMIT=5 with AW and W together
        wr(4'h4, 32'h5, 4'hF);
        rd(4'h4, v); chk("lim_same_cycle", v, 32'h5);

        // LIMIT=5 with AW leading W by 3 cycles
        wr(4'h4, 32'h0, 4'hF);
        rd(4'h4, v); chk("lim_cleared", v, 32'h0);
        awaddr = 4'h4; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        chk("awlead_awready", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        chk("awlead_no_bvalid_1", {31'b0, bvalid}, 32'd0);
        tick();
        tick();
        chk("awlead_no_bvalid_3", {31'b0, bvalid}, 32'd0);
        wvalid = 1'b1;
        chk("awlead_wready", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        chk("awlead_bvalid", {31'b0, bvalid}, 32'd1);
        chk("awlead_bresp", {30'b0, bresp}, 32'd0);
        rd(4'h4, v); chk("lim_aw_lead", v, 32'h5);

        // Strobed write: only byte 1 lands
        wr(4'h4, 32'h0, 4'hF);
        wr(4'h4, 32'hAABBCCDD, 4'b0010);
        rd(4'h4, v); chk("lim_strobe", v, 32'h0000CC00);

        // Read backpressure on LIMIT
        tick();
        rready = 1'b0;
        araddr = 4'h4;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        chk("bp_rvalid_first", {31'b0, rvalid}, 32'd1);
        chk("bp_rdata_first", rdata, 32'h0000CC00);
        held = rdata;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rvalid_hold", {31'b0, rvalid}, 32'd1);
            chk("bp_rdata_hold", rdata, 32'h0000CC00);
            chk("bp_arready_low", {31'b0, arready}, 32'd0);
        end
        rready = 1'b1;
        tick();
        chk("bp_rvalid_done", {31'b0, rvalid}, 32'd0);
        chk("bp_arready_back", {31'b0, arready}, 32'd1);
        chk("bp_rdata_unchanged", rdata, held);

        // Counter collisions with EN=1
        wr(4'h0, 32'h1, 4'hF);
        wr(4'h8, 32'h10, 4'hF);
        chk("coll_load", count_out, 32'h10);
        tick();
        chk("coll_inc_after_load", count_out, 32'h11);
        wr(4'h0, 32'h3, 4'hF);
        chk("coll_clr", count_out, 32'h0);
        tick();
        chk("coll_inc_after_clr", count_out, 32'h1);
        rd(4'h0, v); chk("coll_ctrl_read", v, 32'h1);
        wr(4'h0, 32'h0, 4'hF);
        rd(4'hC, v); chk("coll_status_clean", v, 32'h0);

        // Wrap with LIMIT=3
        wr(4'h4, 32'h3, 4'hF);
        wr(4'h0, 32'h3, 4'hF);
        chk("wrap_c0", count_out, 32'd0);
        chk("wrap_p0", {31'b0, wrap_pulse}, 32'd0);
        tick();
        chk("wrap_c1", count_out, 32'd1);
        chk("wrap_p1", {31'b0, wrap_pulse}, 32'd0);
        tick();
        chk("wrap_c2", count_out, 32'd2);
        chk("wrap_p2", {31'b0, wrap_pulse}, 32'd0);
        tick();
        chk("wrap_c3", count_out, 32'd3);
        chk("wrap_p3", {31'b0, wrap_pulse}, 32'd0);
        tick();
        chk("wrap_c4", count_out, 32'd0);
        chk("wrap_p4", {31'b0, wrap_pulse}, 32'd1);
        wr(4'h0, 32'h0, 4'hF);
        chk("wrap_c5", count_out, 32'd1);
        chk("wrap_p5", {31'b0, wrap_pulse}, 32'd0);
        rd(4'hC, v); chk("wrap_status_set", v, 32'h1);
        wr(4'hC, 32'h1, 4'hF);
        rd(4'hC, v); chk("wrap_status_w1c", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
